// File: rtl/egreedy_action_src.sv
// -----------------------------------------------------------------------------
// egreedy_action_src
//
// Random-action and greedy/explore selection source for a two-intersection
// Q-learning core. Each accepted step advances two independent 16-bit Galois
// LFSRs, one per agent. Each LFSR supplies a random action (low two bits) and
// a greedy/explore decision: its upper byte is compared with the greedy
// threshold. Over time the threshold rises on a fixed step schedule
// (epsilon decay), so the agents explore less and exploit more.
//
// Ports
//   clk         in   1   clock
//   rst         in   1   asynchronous reset, active-high
//   step        in   1   one-cycle strobe: produce one new action pair
//   decay_en    in   1   1 = step counter/threshold advance, 0 = schedule frozen
//   seed_ld     in   1   load seed_in_A/seed_in_B into the LFSRs (wins over step)
//   seed_in_A   in  16   runtime seed, agent A (0 is replaced by 16'h0001)
//   seed_in_B   in  16   runtime seed, agent B (0 is replaced by 16'h0001)
//   Arand_A     out  2   random action, agent A
//   Arand_B     out  2   random action, agent B
//   Asel_A      out  1   1 = take greedy action, 0 = take Arand_A
//   Asel_B      out  1   1 = take greedy action, 0 = take Arand_B
//   act_vld     out  1   one-cycle pulse: outputs updated this cycle
//   greed_thr   out  8   current greedy threshold
// -----------------------------------------------------------------------------
module egreedy_action_src #(
  parameter logic [15:0] SEED_A       = 16'hACE1,
  parameter logic [15:0] SEED_B       = 16'h1D2B,
  parameter logic [7:0]  GREED_INIT   = 8'd26,
  parameter logic [7:0]  GREED_STEP   = 8'd16,
  parameter logic [7:0]  GREED_MAX    = 8'd230,
  parameter int          DECAY_PERIOD = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        decay_en,
  input  logic        seed_ld,
  input  logic [15:0] seed_in_A,
  input  logic [15:0] seed_in_B,
  output logic [1:0]  Arand_A,
  output logic [1:0]  Arand_B,
  output logic        Asel_A,
  output logic        Asel_B,
  output logic        act_vld,
  output logic [7:0]  greed_thr
);

  // Feedback mask for x^16 + x^14 + x^13 + x^11 + 1 in right-shift Galois form.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // The all-zero state is the LFSR's lock-up state, so it is never loaded.
  localparam logic [15:0] SEED_A_SAFE = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SEED_B_SAFE = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;

  // A period of 1 still needs a 1-bit counter to keep the vector legal.
  localparam int                CNT_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_PERIOD - 1);

  function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [15:0] seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

  logic [15:0]      lfsr_a;
  logic [15:0]      lfsr_b;
  logic [CNT_W-1:0] step_cnt;

  logic [15:0] nxt_a;
  logic [15:0] nxt_b;
  logic        step_go;
  logic        cnt_adv;
  logic        decay_hit;
  logic [8:0]  thr_sum;
  logic [7:0]  thr_bumped;

  // NOTE: every signal assigned in an always_comb gets a default value at the
  // top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    nxt_a      = lfsr_advance(lfsr_a);
    nxt_b      = lfsr_advance(lfsr_b);
    // A seed load takes priority. A step in the same cycle is dropped.
    step_go    = step & ~seed_ld;
    cnt_adv    = step_go & decay_en;
    decay_hit  = cnt_adv & (step_cnt == CNT_LAST);
    // Add in 9 bits so a threshold near 255 saturates and does not wrap.
    thr_sum    = {1'b0, greed_thr} + {1'b0, GREED_STEP};
    thr_bumped = greed_thr;
    if (thr_sum > {1'b0, GREED_MAX}) begin
      thr_bumped = GREED_MAX;
    end else begin
      thr_bumped = thr_sum[7:0];
    end
  end

  // LFSR state: reload on seed_ld, advance on an accepted step.
  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_a <= SEED_A_SAFE;
      lfsr_b <= SEED_B_SAFE;
    end else if (seed_ld) begin
      lfsr_a <= seed_fix(seed_in_A);
      lfsr_b <= seed_fix(seed_in_B);
    end else if (step_go) begin
      lfsr_a <= nxt_a;
      lfsr_b <= nxt_b;
    end
  end

  // Action outputs are derived from the new LFSR value. The greedy compare
  // uses the threshold as it stood before any decay update on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Arand_A <= 2'd0;
      Arand_B <= 2'd0;
      Asel_A  <= 1'b0;
      Asel_B  <= 1'b0;
      act_vld <= 1'b0;
    end else begin
      act_vld <= step_go;
      if (step_go) begin
        Arand_A <= nxt_a[1:0];
        Arand_B <= nxt_b[1:0];
        Asel_A  <= (nxt_a[15:8] < greed_thr);
        Asel_B  <= (nxt_b[15:8] < greed_thr);
      end
    end
  end

  // Epsilon-decay schedule: count accepted steps and raise the threshold
  // once per DECAY_PERIOD steps, saturating at GREED_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt  <= '0;
      greed_thr <= GREED_INIT;
    end else if (cnt_adv) begin
      if (decay_hit) begin
        step_cnt  <= '0;
        greed_thr <= thr_bumped;
      end else begin
        step_cnt  <= step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_egreedy_action_src.sv
// -----------------------------------------------------------------------------
// tb_egreedy_action_src
//
// Two instances share all inputs:
//   d0: DECAY_PERIOD=4, GREED_INIT=26   (decay schedule, seeding, reset)
//   d1: DECAY_PERIOD=1, GREED_INIT=128  (fast saturation, 50% greedy statistics)
// A behavioural model of each instance is checked every cycle. Hand-computed
// literal expectations anchor the model at key points.
// -----------------------------------------------------------------------------
module tb_egreedy_action_src;

  logic        clk;
  logic        rst;
  logic        step;
  logic        decay_en;
  logic        seed_ld;
  logic [15:0] seed_in_A;
  logic [15:0] seed_in_B;

  logic [1:0] ar_a0, ar_b0, ar_a1, ar_b1;
  logic       as_a0, as_b0, as_a1, as_b1;
  logic       vld0, vld1;
  logic [7:0] thr0, thr1;

  egreedy_action_src #(.DECAY_PERIOD(4), .GREED_INIT(8'd26)) dut0 (
    .clk(clk), .rst(rst), .step(step), .decay_en(decay_en), .seed_ld(seed_ld),
    .seed_in_A(seed_in_A), .seed_in_B(seed_in_B),
    .Arand_A(ar_a0), .Arand_B(ar_b0), .Asel_A(as_a0), .Asel_B(as_b0),
    .act_vld(vld0), .greed_thr(thr0)
  );

  egreedy_action_src #(.DECAY_PERIOD(1), .GREED_INIT(8'd128)) dut1 (
    .clk(clk), .rst(rst), .step(step), .decay_en(decay_en), .seed_ld(seed_ld),
    .seed_in_A(seed_in_A), .seed_in_B(seed_in_B),
    .Arand_A(ar_a1), .Arand_B(ar_b1), .Asel_A(as_a1), .Asel_B(as_b1),
    .act_vld(vld1), .greed_thr(thr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d expected=[%0d..%0d]", name, act, lo, hi);
    end
  endtask

  // ---------------- behavioural model --------------------------------------
  // Index k = instance, a = agent (0 = A, 1 = B).
  int PERIOD [2] = '{4, 1};
  int INIT   [2] = '{26, 128};
  int m_lfsr [2][2];
  int m_ar   [2][2];
  int m_as   [2][2];
  int m_vld  [2];
  int m_thr  [2];
  int m_cnt  [2];

  function automatic int galois(input int l);
    return (l / 2) ^ ((l % 2 == 1) ? 'hB400 : 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_lfsr[k][0] = 'hACE1;
        m_lfsr[k][1] = 'h1D2B;
        m_ar[k][0] = 0; m_ar[k][1] = 0;
        m_as[k][0] = 0; m_as[k][1] = 0;
        m_vld[k] = 0;
        m_thr[k] = INIT[k];
        m_cnt[k] = 0;
      end else if (seed_ld) begin
        m_lfsr[k][0] = (seed_in_A == 0) ? 1 : int'(seed_in_A);
        m_lfsr[k][1] = (seed_in_B == 0) ? 1 : int'(seed_in_B);
        m_vld[k] = 0;
      end else if (step) begin
        for (int a = 0; a < 2; a++) begin
          m_lfsr[k][a] = galois(m_lfsr[k][a]);
          m_ar[k][a]   = m_lfsr[k][a] % 4;
          m_as[k][a]   = ((m_lfsr[k][a] / 256) < m_thr[k]) ? 1 : 0;
        end
        m_vld[k] = 1;
        if (decay_en) begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == PERIOD[k]) begin
            m_cnt[k] = 0;
            m_thr[k] = (m_thr[k] + 16 > 230) ? 230 : m_thr[k] + 16;
          end
        end
      end else begin
        m_vld[k] = 0;
      end
    end
  end

  task automatic cmp_inst(input int k, input logic [1:0] ara, input logic [1:0] arb,
                          input logic sa, input logic sb, input logic v,
                          input logic [7:0] thr);
    check($sformatf("d%0d_arand_a", k), ara, m_ar[k][0]);
    check($sformatf("d%0d_arand_b", k), arb, m_ar[k][1]);
    check($sformatf("d%0d_asel_a", k), sa, m_as[k][0]);
    check($sformatf("d%0d_asel_b", k), sb, m_as[k][1]);
    check($sformatf("d%0d_act_vld", k), v, m_vld[k]);
    check($sformatf("d%0d_greed_thr", k), thr, m_thr[k]);
  endtask

  // ---------------- per-cycle compare + statistics --------------------------
  logic chk_en  = 1'b0;
  logic stat_en = 1'b0;
  int   sel_cnt = 0;
  int   ar_cnt [4] = '{0, 0, 0, 0};
  int   vld_cnt = 0;
  int   zero_seen = 0;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      cmp_inst(0, ar_a0, ar_b0, as_a0, as_b0, vld0, thr0);
      cmp_inst(1, ar_a1, ar_b1, as_a1, as_b1, vld1, thr1);
      if (dut0.lfsr_a == 16'h0 || dut0.lfsr_b == 16'h0 ||
          dut1.lfsr_a == 16'h0 || dut1.lfsr_b == 16'h0) zero_seen++;
    end
    if (stat_en && vld1) begin
      vld_cnt++;
      if (as_a1) sel_cnt++;
      ar_cnt[ar_a1]++;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // n back-to-back accepted steps; returns on the negedge after the last edge.
  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step = 1'b1;
    end
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic check_t1(input string tag);
    check({tag, "_arand_a"}, ar_a0, 2'd0);
    check({tag, "_asel_a"},  as_a0, 1'b0);
    check({tag, "_arand_b"}, ar_b0, 2'd1);
    check({tag, "_asel_b"},  as_b0, 1'b0);
    check({tag, "_act_vld"}, vld0, 1'b1);
    check({tag, "_lfsr_a"},  dut0.lfsr_a, 16'hE270);
    check({tag, "_lfsr_b"},  dut0.lfsr_b, 16'hBA95);
    check({tag, "_d1_asel_a"}, as_a1, 1'b0);
    check({tag, "_d1_asel_b"}, as_b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int cnt_before;

  initial begin
    rst = 1'b1; step = 1'b0; decay_en = 1'b0; seed_ld = 1'b0;
    seed_in_A = 16'h0; seed_in_B = 16'h0;
    do_reset();
    chk_en = 1'b1;

    // Reset state
    check("rst_act_vld", vld0, 1'b0);
    check("rst_arand_a", ar_a0, 2'd0);
    check("rst_thr_d0", thr0, 8'd26);
    check("rst_thr_d1", thr1, 8'd128);
    check("rst_lfsr_a", dut0.lfsr_a, 16'hACE1);

    // T1: single step from reset
    step_n(1);
    check_t1("t1");
    @(negedge clk);
    check("t1_vld_drop", vld0, 1'b0);

    // T6: 10k steps at threshold 128 (instance d1, schedule frozen)
    do_reset();
    stat_en = 1'b1;
    step_n(10000);
    @(negedge clk);
    stat_en = 1'b0;
    check("t6_vld_count", vld_cnt, 10000);
    check_range("t6_asel_a_ratio", sel_cnt, 4800, 5200);
    for (int v = 0; v < 4; v++)
      check_range($sformatf("t6_arand_%0d", v), ar_cnt[v], 2300, 2700);
    check("t6_thr_frozen", thr1, 8'd128);

    // T2: decay schedule
    do_reset();
    decay_en = 1'b1;
    step_n(4);
    check("t2_thr_42", thr0, 8'd42);
    check("t2_d1_thr_192", thr1, 8'd192);
    step_n(4);
    check("t2_thr_58", thr0, 8'd58);
    check("t2_d1_thr_230", thr1, 8'd230);
    decay_en = 1'b0;
    step_n(10);
    check("t2_thr_frozen", thr0, 8'd58);

    // T3: run to saturation; 62 steps leaves step_cnt at 2
    decay_en = 1'b1;
    step_n(62);
    check("t3_thr_sat", thr0, 8'd230);
    check("t3_d1_thr_sat", thr1, 8'd230);
    check("t3_step_cnt", dut0.step_cnt, 2'd2);

    // T4: seed load with zero seed wins over step
    cnt_before = m_cnt[0];
    @(negedge clk);
    seed_ld = 1'b1; step = 1'b1; seed_in_A = 16'h0000; seed_in_B = 16'h1234;
    @(negedge clk);
    seed_ld = 1'b0; step = 1'b0;
    check("t4_lfsr_a", dut0.lfsr_a, 16'h0001);
    check("t4_lfsr_b", dut0.lfsr_b, 16'h1234);
    check("t4_act_vld", vld0, 1'b0);
    check("t4_step_cnt", dut0.step_cnt, cnt_before);
    check("t4_step_cnt_lit", dut0.step_cnt, 2'd2);
    step_n(1);
    check("t4_arand_a", ar_a0, 2'd0);
    check("t4_lfsr_a_next", dut0.lfsr_a, 16'hB400);
    check("t4_lfsr_b_next", dut0.lfsr_b, 16'h091A);

    // T5: async reset mid-stream with step held high
    decay_en = 1'b0;
    @(negedge clk);
    step = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_async_vld", vld0, 1'b0);
    check("t5_async_arand_b", ar_b0, 2'd0);
    check("t5_async_asel_a", as_a1, 1'b0);
    check("t5_async_thr", thr0, 8'd26);
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step_n(1);
    check_t1("t5");

    check("lfsr_never_zero", zero_seen, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
